// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter.
// Divides mck_i down to a bit clock and a word-select, then serializes one
// stereo pair per frame. Each word goes out left first, MSB first, one BCK
// after the LRCK edge. Slot bits beyond FRAME are sent as 0. Pairs enter
// through a single-entry valid/ready holding buffer. A frame that starts
// with the buffer empty sends silence and raises underrun_o for one mck cycle.
//
// Ports:
//   mck_i       master clock (only clock)
//   rst_i       asynchronous reset, active low
//   en_i        transmit enable; low holds the serial side idle
//   l_data_i    left sample (FRAME bits, two's complement)
//   r_data_i    right sample (FRAME bits, two's complement)
//   s_valid_i   sample pair valid
//   s_ready_o   holding buffer can accept a pair
//   bck_o       bit clock
//   lrck_o      word select, 0 = left, 1 = right
//   data_o      serial data, changes on the BCK falling edge
//   underrun_o  one-mck pulse when a frame starts with no pair pending
module i2s_tx #(
    parameter int FRAME   = 24,
    parameter int SLOT    = 32,
    parameter int MCK_DIV = 4
) (
    input  logic             mck_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [FRAME-1:0] l_data_i,
    input  logic [FRAME-1:0] r_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic             bck_o,
    output logic             lrck_o,
    output logic             data_o,
    output logic             underrun_o
);
    localparam int PW = $clog2(2 * SLOT);
    localparam int DW = $clog2(MCK_DIV);
    localparam logic [DW-1:0] D_LAST  = DW'(MCK_DIV - 1);
    localparam logic [DW-1:0] D_HALF  = DW'(MCK_DIV / 2);
    localparam logic [PW-1:0] P_LAST  = PW'(2 * SLOT - 1);
    localparam logic [PW-1:0] P_SLOT  = PW'(SLOT);
    localparam logic [PW-1:0] P_FRAME = PW'(FRAME);
    localparam logic [PW-1:0] P_LOAD  = PW'(1'b1);

    logic [DW-1:0]    d_r;
    logic [DW-1:0]    d_next_s;
    logic [PW-1:0]    p_r;
    logic [PW-1:0]    p_next_s;
    logic [PW-1:0]    bit_idx_s;
    logic [FRAME-1:0] word_s;
    logic [FRAME-1:0] act_l_r;
    logic [FRAME-1:0] act_r_r;
    logic [FRAME-1:0] buf_l_r;
    logic [FRAME-1:0] buf_r_r;
    logic             buf_full_r;
    logic             fall_tick_s;
    logic             load_s;
    logic             accept_s;
    logic             bck_next_s;
    logic             data_next_s;

    // Bit idx of a word counted from the MSB; slot padding past FRAME is 0.
    function automatic logic word_bit(input logic [FRAME-1:0] word,
                                      input logic [PW-1:0]    idx);
        logic [FRAME-1:0] shifted;
        shifted = word << idx;
        if (idx < P_FRAME) begin
            word_bit = shifted[FRAME-1];
        end else begin
            word_bit = 1'b0;
        end
    endfunction

    assign s_ready_o = ~buf_full_r;

    // Next divider/position values, load and accept strobes, next serial bit.
    always_comb begin
        d_next_s    = {DW{1'b0}};
        p_next_s    = {PW{1'b0}};
        bit_idx_s   = {PW{1'b0}};
        word_s      = {FRAME{1'b0}};
        data_next_s = 1'b0;

        if (d_r == D_LAST) begin
            d_next_s = {DW{1'b0}};
        end else begin
            d_next_s = d_r + DW'(1'b1);
        end
        bck_next_s = (d_next_s >= D_HALF);

        if (p_r == P_LAST) begin
            p_next_s = {PW{1'b0}};
        end else begin
            p_next_s = p_r + PW'(1'b1);
        end

        fall_tick_s = en_i & (d_r == D_LAST);
        load_s      = fall_tick_s & (p_next_s == P_LOAD);
        accept_s    = s_valid_i & ~buf_full_r;

        // The bit sent for p_new is slot position p_new-1, which is the current p_r.
        if (p_r < P_SLOT) begin
            word_s    = act_l_r;
            bit_idx_s = p_r;
        end else begin
            word_s    = act_r_r;
            bit_idx_s = p_r - P_SLOT;
        end

        // On the load edge the left MSB comes from the word being loaded.
        if (load_s) begin
            if (buf_full_r) begin
                data_next_s = buf_l_r[FRAME-1];
            end else begin
                data_next_s = 1'b0;
            end
        end else begin
            data_next_s = word_bit(word_s, bit_idx_s);
        end
    end

    // Divider, frame position and all registered serial outputs.
    always_ff @(posedge mck_i or negedge rst_i) begin
        if (!rst_i) begin
            d_r        <= {DW{1'b0}};
            p_r        <= {PW{1'b0}};
            bck_o      <= 1'b0;
            lrck_o     <= 1'b0;
            data_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else if (!en_i) begin
            d_r        <= {DW{1'b0}};
            p_r        <= {PW{1'b0}};
            bck_o      <= 1'b0;
            lrck_o     <= 1'b0;
            data_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            d_r        <= d_next_s;
            bck_o      <= bck_next_s;
            underrun_o <= 1'b0;
            if (fall_tick_s) begin
                p_r        <= p_next_s;
                lrck_o     <= (p_next_s >= P_SLOT);
                data_o     <= data_next_s;
                underrun_o <= load_s & ~buf_full_r;
            end
        end
    end

    // Single-entry holding buffer; a load and an accept on one edge keep it full.
    always_ff @(posedge mck_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_full_r <= 1'b0;
            buf_l_r    <= {FRAME{1'b0}};
            buf_r_r    <= {FRAME{1'b0}};
        end else begin
            buf_full_r <= accept_s | (buf_full_r & ~load_s);
            if (accept_s) begin
                buf_l_r <= l_data_i;
                buf_r_r <= r_data_i;
            end
        end
    end

    // Active words for the frame in flight; silence when the frame underruns.
    always_ff @(posedge mck_i or negedge rst_i) begin
        if (!rst_i) begin
            act_l_r <= {FRAME{1'b0}};
            act_r_r <= {FRAME{1'b0}};
        end else if (load_s) begin
            if (buf_full_r) begin
                act_l_r <= buf_l_r;
                act_r_r <= buf_r_r;
            end else begin
                act_l_r <= {FRAME{1'b0}};
                act_r_r <= {FRAME{1'b0}};
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx.
// Two instances share mck/reset/enable: the default build (SLOT=32) and a
// SLOT=FRAME=24 build. A cycle-count reference model derives every expected
// output from the number of enabled mck edges since enable, using division
// and modulo, plus a model of the holding buffer.
module tb_i2s_tx;
    localparam int FRAME   = 24;
    localparam int MCK_DIV = 4;
    localparam int SLOT_A  = 32;
    localparam int SLOT_B  = 24;

    logic             mck;
    logic             rst_n;
    logic             en;
    logic [FRAME-1:0] l_data [2];
    logic [FRAME-1:0] r_data [2];
    logic [1:0]       valid;
    logic [1:0]       ready;
    logic [1:0]       bck;
    logic [1:0]       lrck;
    logic [1:0]       sdata;
    logic [1:0]       und;

    // Reference model state.
    int               n;
    bit               mfull    [2];
    bit               last_acc [2];
    bit               exp_und  [2];
    logic [FRAME-1:0] bl [2];
    logic [FRAME-1:0] br [2];
    logic [FRAME-1:0] cl [2];
    logic [FRAME-1:0] cr [2];

    int checks;
    int passed;
    int vprob;
    bit rnd_stim;

    i2s_tx #(.FRAME(FRAME), .SLOT(SLOT_A), .MCK_DIV(MCK_DIV)) dut_a (
        .mck_i(mck), .rst_i(rst_n), .en_i(en),
        .l_data_i(l_data[0]), .r_data_i(r_data[0]), .s_valid_i(valid[0]),
        .s_ready_o(ready[0]), .bck_o(bck[0]), .lrck_o(lrck[0]),
        .data_o(sdata[0]), .underrun_o(und[0])
    );

    i2s_tx #(.FRAME(FRAME), .SLOT(SLOT_B), .MCK_DIV(MCK_DIV)) dut_b (
        .mck_i(mck), .rst_i(rst_n), .en_i(en),
        .l_data_i(l_data[1]), .r_data_i(r_data[1]), .s_valid_i(valid[1]),
        .s_ready_o(ready[1]), .bck_o(bck[1]), .lrck_o(lrck[1]),
        .data_o(sdata[1]), .underrun_o(und[1])
    );

    initial mck = 1'b0;
    always #5 mck = ~mck;

    function automatic int slot_of(input int i);
        return (i == 0) ? SLOT_A : SLOT_B;
    endfunction

    // Expected {ready, bck, lrck, data, underrun} from the cycle count.
    function automatic logic [4:0] expect_out(input int i);
        int         f;
        int         k;
        int         b;
        int         s;
        logic [FRAME-1:0] w;
        logic       bk;
        logic       lr;
        logic       dt;
        s  = slot_of(i);
        bk = 1'b0;
        lr = 1'b0;
        dt = 1'b0;
        if (n > 0) begin
            bk = ((n % MCK_DIV) >= (MCK_DIV / 2));
            f  = n / MCK_DIV;
            lr = ((f % (2 * s)) >= s);
            if (f > 0) begin
                k = (f - 1) % (2 * s);
                w = (k < s) ? cl[i] : cr[i];
                b = k % s;
                if (b < FRAME) dt = w[FRAME-1-b];
            end
        end
        return {~mfull[i], bk, lr, dt, exp_und[i]};
    endfunction

    task automatic check_out(input string tag);
        logic [4:0] obs;
        logic [4:0] exp;
        for (int i = 0; i < 2; i++) begin
            obs = {ready[i], bck[i], lrck[i], sdata[i], und[i]};
            exp = expect_out(i);
            checks++;
            assert (obs === exp) passed++;
            else $error("FAIL %s inst%0d n=%0d observed=%b expected=%b (ready,bck,lrck,data,underrun)",
                        tag, i, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 2; i++) begin
            mfull[i]    = 1'b0;
            last_acc[i] = 1'b0;
            exp_und[i]  = 1'b0;
            bl[i] = '0; br[i] = '0; cl[i] = '0; cr[i] = '0;
        end
    endtask

    // One mck edge: advance the model from the inputs present at the edge, then check.
    task automatic cycle(input string tag);
        bit acc;
        bit load;
        @(posedge mck);
        if (en) n++;
        else n = 0;
        for (int i = 0; i < 2; i++) begin
            acc  = valid[i] && !mfull[i];
            load = en && (n % MCK_DIV == 0) && (((n / MCK_DIV) % (2 * slot_of(i))) == 1);
            exp_und[i] = load && !mfull[i];
            if (load) begin
                cl[i] = mfull[i] ? bl[i] : '0;
                cr[i] = mfull[i] ? br[i] : '0;
            end
            if (acc) begin
                bl[i] = l_data[i];
                br[i] = r_data[i];
            end
            mfull[i]    = acc || (mfull[i] && !load);
            last_acc[i] = acc;
        end
        #1;
        check_out(tag);
    endtask

    // New random pair unless the previous one is still held off.
    task automatic drive_random();
        for (int i = 0; i < 2; i++) begin
            if (!(valid[i] && !last_acc[i])) begin
                if (int'($urandom_range(99)) < vprob) begin
                    valid[i]  = 1'b1;
                    l_data[i] = FRAME'($urandom);
                    r_data[i] = FRAME'($urandom);
                end else begin
                    valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic run(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            if (rnd_stim) drive_random();
            cycle(tag);
        end
    endtask

    initial begin
        int guard;
        checks   = 0;
        passed   = 0;
        vprob    = 0;
        rnd_stim = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b0;
        valid    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            l_data[i] = '0;
            r_data[i] = '0;
        end
        model_reset();
        #1;
        check_out("reset");
        #1;
        rst_n = 1'b1;

        // Preload known pairs while disabled, then send them plus an underrun frame.
        valid     = 2'b11;
        l_data[0] = 24'h800001; r_data[0] = 24'h7FFFFE;
        l_data[1] = 24'hFFFFFF; r_data[1] = 24'h000001;
        cycle("preload");
        valid = 2'b00;
        en    = 1'b1;
        run(600, "pattern");

        // Random sparse traffic, then back-to-back pairs.
        rnd_stim = 1'b1;
        vprob    = 30;
        run(2000, "random");
        vprob = 100;
        run(800, "back_to_back");

        // Drop enable in the middle of the right channel, then restart.
        vprob = 50;
        guard = 0;
        while (!((((n / MCK_DIV) % (2 * SLOT_A)) == 40) && (n % MCK_DIV == 1)) && guard < 600) begin
            run(1, "pre_disable");
            guard++;
        end
        checks++;
        assert (guard < 600) passed++;
        else $error("FAIL mid_right_wait observed=%0d expected<600", guard);
        en = 1'b0;
        run(20, "disabled");
        en = 1'b1;
        run(600, "restart");

        // Reset mid-word with a pair buffered.
        vprob = 100;
        guard = 0;
        while (!mfull[0] && guard < 300) begin
            run(1, "pre_reset");
            guard++;
        end
        checks++;
        assert (guard < 300) passed++;
        else $error("FAIL buffer_fill_wait observed=%0d expected<300", guard);
        run(7, "pre_reset");
        #2;
        rst_n    = 1'b0;
        valid    = 2'b00;
        rnd_stim = 1'b0;
        #1;
        model_reset();
        check_out("async_reset");
        @(posedge mck);
        @(posedge mck);
        #1;
        check_out("reset_hold");
        rst_n = 1'b1;
        run(600, "after_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
